shift_rate_ctrl: RTL
====================

Name: shift_rate_ctrl

Overview:
Rate controller and sequencer for the ball shift datapath of the handball game. Runs on the 100 MHz board clock and produces single-cycle shift-enable pulses that step the ball register. Sequences serve delay, run, pause and game-over. Shortens the shift period (faster ball) each time a player returns the ball.

Parameters:
BASE_DIV, 25000000, shift period in CLKIN cycles at LEVEL 0 (4 Hz at 100 MHz)
STEP_DIV, 2500000, period reduction in cycles per level
MAX_LEVEL, 7, saturating maximum speed level
SERVE_DIV, 50000000, serve delay in CLKIN cycles before the first shift
CNT_W, 26, counter width; must hold max(BASE_DIV, SERVE_DIV)-1

Ports:
CLKIN  in  1  system clock, 100 MHz, rising edge
RST_N  in  1  asynchronous active-low reset
START  in  1  one-cycle pulse; serve request
HIT  in  1  one-cycle pulse; player returned ball
MISS  in  1  one-cycle pulse; ball lost, end rally
PAUSE  in  1  level; freeze play while high
SHIFT_EN  out  1  one-cycle pulse; advance ball register
LEVEL  out  3  current speed level
RUNNING  out  1  high in RUN or PAUSED
STATE  out  2  IDLE=0, SERVE=1, RUN=2, PAUSED=3

Behaviour:
- Reset (RST_N low, asynchronous): STATE=IDLE, counter=0, LEVEL=0, SHIFT_EN=0, RUNNING=0. All outputs are registered.
- Legal parameters require BASE_DIV - MAX_LEVEL*STEP_DIV >= 2 and SERVE_DIV >= 1.
- Period = BASE_DIV - LEVEL*STEP_DIV. Compute it at CNT_W bits, unsigned; it can never underflow under the legal-parameter rule.
- IDLE:
  - START -> SERVE, counter=0.
  - HIT, MISS and PAUSE are ignored.
- SERVE:
  - Counter increments each cycle.
  - When counter==SERVE_DIV-1: go to RUN, counter=0.
  - No SHIFT_EN is issued. PAUSE is ignored.
  - MISS -> IDLE.
- RUN:
  - Counter increments each cycle.
  - When counter==period-1: SHIFT_EN=1 for exactly one cycle, counter=0.
  - First SHIFT_EN occurs on the period-th cycle after entering RUN.
- HIT in RUN:
  - LEVEL <= min(LEVEL+1, MAX_LEVEL) and counter=0. The new period applies from the next count.
  - If HIT coincides with terminal count, SHIFT_EN still pulses that cycle.
- PAUSE high in RUN -> PAUSED. Counter frozen, no SHIFT_EN.
- PAUSE low in PAUSED -> RUN, resuming from the frozen count. Net effect: the pending SHIFT_EN is delayed by exactly the number of PAUSED cycles.
- HIT in PAUSED is ignored.
- MISS in any non-IDLE state -> IDLE, LEVEL=0, counter=0, SHIFT_EN=0 (no pulse in that cycle).
- Priority when inputs coincide: MISS > HIT > PAUSE > terminal count.
- START outside IDLE is ignored. A rally in progress is never restarted.
- RUNNING = (STATE==RUN) or (STATE==PAUSED).

Test Plan:
Parameters for bench: BASE_DIV=10, STEP_DIV=2, MAX_LEVEL=3, SERVE_DIV=5.
1. Reset and idle: RST_N low then high, toggle HIT/MISS/PAUSE -> STATE=0, LEVEL=0, SHIFT_EN never asserted, RUNNING=0.
2. Serve and run: START pulse -> STATE=1 for 5 cycles, then STATE=2. First SHIFT_EN on the 10th RUN cycle, then every 10 cycles, each 1 cycle wide.
3. Speed-up and saturation: four HIT pulses, each followed by 3 SHIFT_ENs -> LEVEL 1,2,3,3 with SHIFT_EN spacing 8,6,4,4 cycles.
4. Pause: PAUSE high for 7 cycles at count 4 -> STATE=3 during pause. Next SHIFT_EN arrives 13 cycles after pause start instead of 6. RUNNING stays 1.
5. Simultaneous MISS+HIT at terminal count -> next cycle STATE=0, LEVEL=0, no SHIFT_EN that cycle or after. A subsequent START restarts the serve with period 10.
6. Async reset mid-run: RST_N low between clock edges at LEVEL=2 in RUN -> outputs go to reset values immediately without a clock edge. They stay there until RST_N is high and a START is received.

Source files
------------

// File: rtl/shift_rate_ctrl.sv
// Ball shift rate controller and rally sequencer for the handball game.
// Issues one-cycle SHIFT_EN pulses whose period shrinks with each return.
//
// Ports:
//   CLKIN    in   board clock, rising edge
//   RST_N    in   asynchronous active-low reset
//   START    in   one-cycle serve request, honoured only in IDLE
//   HIT      in   one-cycle pulse, player returned the ball (RUN only)
//   MISS     in   one-cycle pulse, ball lost, ends the rally
//   PAUSE    in   level, freezes play while high (RUN/PAUSED only)
//   SHIFT_EN out  one-cycle pulse, advance the ball register
//   LEVEL    out  current speed level (0..MAX_LEVEL)
//   RUNNING  out  high in RUN or PAUSED
//   STATE    out  IDLE=0, SERVE=1, RUN=2, PAUSED=3
module shift_rate_ctrl #(
    parameter int unsigned BASE_DIV  = 25000000,
    parameter int unsigned STEP_DIV  = 2500000,
    parameter int unsigned MAX_LEVEL = 7,
    parameter int unsigned SERVE_DIV = 50000000,
    parameter int unsigned CNT_W     = 26
) (
    input  logic       CLKIN,
    input  logic       RST_N,
    input  logic       START,
    input  logic       HIT,
    input  logic       MISS,
    input  logic       PAUSE,
    output logic       SHIFT_EN,
    output logic [2:0] LEVEL,
    output logic       RUNNING,
    output logic [1:0] STATE
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SERVE  = 2'd1,
        S_RUN    = 2'd2,
        S_PAUSED = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] BASE_C     = CNT_W'(BASE_DIV);
    localparam logic [CNT_W-1:0] STEP_C     = CNT_W'(STEP_DIV);
    localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1);
    localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_DIV - 1);
    localparam logic [2:0]       MAX_C      = 3'(MAX_LEVEL);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       level_q, level_d;
    logic             shift_q, shift_d;

    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] cnt_inc;
    logic             period_end;
    logic             serve_end;
    logic [2:0]       level_up;

    // Legal parameters keep the period >= 2, so this never wraps.
    assign period     = BASE_C - (CNT_W'(level_q) * STEP_C);
    assign cnt_inc    = cnt_q + ONE_C;
    assign period_end = (cnt_q == (period - ONE_C));
    assign serve_end  = (cnt_q == SERVE_LAST);
    assign level_up   = (level_q < MAX_C) ? (level_q + 3'd1) : level_q;

    always_ff @(posedge CLKIN or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            level_q <= '0;
            shift_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        shift_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (START) begin
                    state_d = S_SERVE;
                    cnt_d   = '0;
                end
            end

            S_SERVE: begin
                if (MISS) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    level_d = '0;
                end else if (serve_end) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            S_RUN: begin
                if (MISS) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    level_d = '0;
                end else if (HIT) begin
                    // A return restarts the count at the new, shorter
                    // period but never swallows a shift already due.
                    level_d = level_up;
                    cnt_d   = '0;
                    shift_d = period_end;
                end else if (PAUSE) begin
                    // Count is held, so a pending shift is delayed by
                    // exactly the number of paused cycles.
                    state_d = S_PAUSED;
                end else if (period_end) begin
                    shift_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            S_PAUSED: begin
                if (MISS) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    level_d = '0;
                end else if (!PAUSE) begin
                    // The resume cycle counts as a running cycle.
                    state_d = S_RUN;
                    if (period_end) begin
                        shift_d = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
        endcase
    end

    assign SHIFT_EN = shift_q;
    assign LEVEL    = level_q;
    assign STATE    = state_q;
    assign RUNNING  = (state_q == S_RUN) || (state_q == S_PAUSED);

endmodule
